// File: rtl/sm_muldiv.sv
// Radix-2 iterative multiply/divide unit with architectural HI/LO registers.
// Define SM_MULDIV_SIGNED_EN to enable signed MULT/DIV (op[1]=1); otherwise op[1] is ignored.
module sm_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hiWe,
    input  logic             loWe,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divZero
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    localparam logic [WIDTH-1:0]   ZERO  = '0;
    localparam logic [2*WIDTH-1:0] ZERO2 = '0;
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   ONE   = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             div_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] w_q;      // multiply accumulator / divide remainder
    logic [WIDTH-1:0] x_q;      // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] b_q;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q, dz_q;

    logic             sa, sb;
    logic [WIDTH-1:0] a_mag, b_mag;

`ifdef SM_MULDIV_SIGNED_EN
    always_comb begin
        sa    = op[1] & srcA[WIDTH-1];
        sb    = op[1] & srcB[WIDTH-1];
        a_mag = sa ? (ZERO - srcA) : srcA;
        b_mag = sb ? (ZERO - srcB) : srcB;
    end
`else
    logic unused_op1;
    assign unused_op1 = op[1];
    always_comb begin
        sa    = 1'b0;
        sb    = 1'b0;
        a_mag = srcA;
        b_mag = srcB;
    end
`endif

    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   dshift;
    logic             dge;
    logic [WIDTH-1:0] w_d, x_d;

    // The WIDTH+1 bit shifted remainder always differs from the divisor by
    // less than 2^WIDTH when dge is set, so a WIDTH-bit subtract suffices.
    always_comb begin
        msum   = {1'b0, w_q} + {1'b0, (x_q[0] ? b_q : ZERO)};
        dshift = {w_q, x_q[WIDTH-1]};
        dge    = (dshift >= {1'b0, b_q});
        if (div_q) begin
            w_d = dge ? (dshift[WIDTH-1:0] - b_q) : dshift[WIDTH-1:0];
            x_d = {x_q[WIDTH-2:0], dge};
        end else begin
            w_d = msum[WIDTH:1];
            x_d = {msum[0], x_q[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    always_comb begin
        prod = neg_res_q ? (ZERO2 - {w_q, x_q}) : {w_q, x_q};
        if (div_q) begin
            fin_lo = neg_res_q ? (ZERO - x_q) : x_q;
            fin_hi = neg_rem_q ? (ZERO - w_q) : w_q;
        end else begin
            fin_lo = prod[WIDTH-1:0];
            fin_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            w_q       <= '0;
            x_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (hiWe) hi_q <= wd;
                    if (loWe) lo_q <= wd;
                    if (start) begin
                        div_q     <= op[0];
                        neg_res_q <= sa ^ sb;
                        neg_rem_q <= sa;
                        w_q       <= '0;
                        x_q       <= a_mag;
                        b_q       <= b_mag;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    w_q   <= w_d;
                    x_q   <= x_d;
                    cnt_q <= cnt_q + ONE;
                    if (cnt_q == LAST) state_q <= FIN;
                end
                FIN: begin
                    hi_q   <= fin_hi;
                    lo_q   <= fin_lo;
                    if (div_q) dz_q <= (b_q == ZERO);
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign divZero = dz_q;

endmodule
